// File: rtl/npu_seq_pkg.sv
// Shared types and defaults for the neuron sequencer.
package npu_seq_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_W_DEF     = 14;
    localparam int unsigned LEN_W_DEF      = 10;
    localparam int unsigned MEM_RD_LAT_MAX = 4;
    localparam int unsigned CH_W           = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_t;

    // One beat of neuron control travelling alongside the memory read.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } ctl_beat_t;

endpackage

// File: rtl/npu_seq_ctl_pipe.sv
// Delays the {valid, first, last} beat by LAT cycles to line up with memory data.
module npu_seq_ctl_pipe
    import npu_seq_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  ctl_beat_t i_ctl,
    output ctl_beat_t o_ctl
);

    ctl_beat_t [LAT-1:0] r_sh;

    if (LAT == 1) begin : g_one
        // single stage: register the beat directly
        always_ff @(posedge clk) begin
            if (rst || i_flush) begin
                r_sh <= '0;
            end else begin
                r_sh[0] <= i_ctl;
            end
        end
    end else begin : g_multi
        // shift toward the top entry, which feeds the neuron
        always_ff @(posedge clk) begin
            if (rst || i_flush) begin
                r_sh <= '0;
            end else begin
                r_sh <= {r_sh[LAT-2:0], i_ctl};
            end
        end
    end

    assign o_ctl = r_sh[LAT-1];

endmodule

// File: rtl/npu_neuron_seq.sv
// Walks one neuron through a layer: per output channel, streams weight/activation
// reads and the matching mac_en/start_p/last_p, optionally waiting for write-back.
module npu_neuron_seq
    import npu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start_p,
    input  logic [LEN_W-1:0]  cfg_num_outputs,
    input  logic [LEN_W-1:0]  cfg_vec_len,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic              cfg_wait_ack,
    input  logic              abort_p,
    input  logic              hw_mem_wr_ack_p,
    output logic              rd_en,
    output logic [ADDR_W-1:0] weight_rd_addr,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              mac_en,
    output logic              start_p,
    output logic              last_p,
    output logic [CH_W-1:0]   ch_num,
    output logic              busy,
    output logic              done_p
);

    // Reject parameter sets the datapath cannot honour.
    if (DATA_WIDTH == 0 || LEN_W < CH_W || MEM_RD_LAT < 1 ||
        MEM_RD_LAT > MEM_RD_LAT_MAX) begin : g_param_check
        $error("npu_neuron_seq: unsupported parameter set");
    end

    seq_state_t        r_state;
    seq_state_t        w_next_state;

    logic [LEN_W-1:0]  r_num_out;
    logic [LEN_W-1:0]  r_vec_len;
    logic [ADDR_W-1:0] r_a_base;
    logic              r_wait_ack;

    logic [LEN_W-1:0]  r_k;
    logic [LEN_W-1:0]  r_out_cnt;
    logic [LEN_W-1:0]  w_out_cnt_next;
    logic [ADDR_W-1:0] r_w_ptr;
    logic [ADDR_W-1:0] r_a_addr;

    logic              r_rd_en;
    logic [CH_W-1:0]   r_ch_num;
    logic              r_busy;
    logic              r_done_p;

    logic              w_start;
    logic              w_abort;
    logic              w_cfg_empty;
    logic              w_issuing;
    logic              w_k_last;
    logic              w_out_last;
    ctl_beat_t         w_issue_ctl;
    ctl_beat_t         w_pipe_out;

    assign w_start     = (r_state == ST_IDLE) && cfg_start_p;
    assign w_abort     = abort_p && (r_state != ST_IDLE);
    assign w_cfg_empty = (cfg_num_outputs == '0) || (cfg_vec_len == '0);
    assign w_issuing   = (r_state == ST_ISSUE);
    assign w_k_last    = (r_k == r_vec_len - LEN_W'(1));
    assign w_out_last  = (r_out_cnt == r_num_out - LEN_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and output-channel count; abort overrides everything.
    always_comb begin
        w_next_state   = r_state;
        w_out_cnt_next = r_out_cnt;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start_p) begin
                    w_out_cnt_next = '0;
                    w_next_state   = w_cfg_empty ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_k_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // leave once the final term of this vector reaches the neuron
                if (w_pipe_out.last) begin
                    if (r_wait_ack) begin
                        w_next_state = ST_WAIT_ACK;
                    end else if (w_out_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state   = ST_ISSUE;
                        w_out_cnt_next = r_out_cnt + LEN_W'(1);
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (hw_mem_wr_ack_p) begin
                    if (w_out_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state   = ST_ISSUE;
                        w_out_cnt_next = r_out_cnt + LEN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next_state   = ST_IDLE;
            w_out_cnt_next = r_out_cnt;
        end
    end

    // Layer configuration, captured only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_out  <= '0;
            r_vec_len  <= '0;
            r_a_base   <= '0;
            r_wait_ack <= 1'b0;
        end else if (w_start) begin
            r_num_out  <= cfg_num_outputs;
            r_vec_len  <= cfg_vec_len;
            r_a_base   <= cfg_a_base;
            r_wait_ack <= cfg_wait_ack;
        end
    end

    // Term counter and read addresses; the weight pointer never rewinds between outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_out_cnt <= '0;
            r_w_ptr   <= '0;
            r_a_addr  <= '0;
        end else begin
            r_out_cnt <= w_out_cnt_next;
            if (w_start) begin
                r_k      <= '0;
                r_w_ptr  <= cfg_w_base;
                r_a_addr <= cfg_a_base;
            end else if (w_issuing) begin
                r_w_ptr <= r_w_ptr + ADDR_W'(1);
                if (w_k_last) begin
                    r_k      <= '0;
                    r_a_addr <= r_a_base;
                end else begin
                    r_k      <= r_k + LEN_W'(1);
                    r_a_addr <= r_a_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Registered strobes derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en  <= 1'b0;
            r_ch_num <= '0;
            r_busy   <= 1'b0;
            r_done_p <= 1'b0;
        end else begin
            r_rd_en  <= (w_next_state == ST_ISSUE);
            r_busy   <= (w_next_state != ST_IDLE);
            r_done_p <= (r_state == ST_DONE) && !w_abort;
            if ((w_next_state == ST_ISSUE) && (r_state != ST_ISSUE)) begin
                r_ch_num <= w_out_cnt_next[CH_W-1:0];
            end
        end
    end

    // Control beat launched alongside each read.
    always_comb begin
        w_issue_ctl       = '0;
        w_issue_ctl.valid = w_issuing;
        w_issue_ctl.first = w_issuing && (r_k == '0);
        w_issue_ctl.last  = w_issuing && w_k_last;
    end

    npu_seq_ctl_pipe #(
        .LAT (MEM_RD_LAT)
    ) u_ctl_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_abort),
        .i_ctl   (w_issue_ctl),
        .o_ctl   (w_pipe_out)
    );

    assign rd_en          = r_rd_en;
    assign weight_rd_addr = r_w_ptr;
    assign act_rd_addr    = r_a_addr;
    assign mac_en         = w_pipe_out.valid;
    assign start_p        = w_pipe_out.first;
    assign last_p         = w_pipe_out.last;
    assign ch_num         = r_ch_num;
    assign busy           = r_busy;
    assign done_p         = r_done_p;

endmodule

// File: tb/tb_npu_neuron_seq.sv
// Bench for npu_neuron_seq: three instances with read latency 1, 2 and 3.
module tb_npu_neuron_seq;

    localparam int unsigned AW = 14;
    localparam int unsigned LW = 10;

    typedef struct packed {
        logic [AW-1:0] w;
        logic [AW-1:0] a;
    } rd_exp_t;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [4:0] ch;
    } mac_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] start_v = '0;
    logic [2:0] abort_v = '0;
    logic [2:0] ack_v   = '0;
    logic [LW-1:0] cfg_n  = '0;
    logic [LW-1:0] cfg_v  = '0;
    logic [AW-1:0] cfg_wb = '0;
    logic [AW-1:0] cfg_ab = '0;
    logic          cfg_wt = 1'b0;

    logic [2:0] rd_o, mac_o, st_o, la_o, busy_o, done_o;
    logic [2:0][AW-1:0] wa_o, aa_o;
    logic [2:0][4:0]    ch_o;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int lat_of [3] = '{1, 2, 3};
    logic [1:0] sel = 2'd0;

    rd_exp_t  rd_q[$];
    mac_exp_t mac_q[$];
    int       due_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        npu_neuron_seq #(
            .MEM_RD_LAT (g + 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .cfg_start_p     (start_v[g]),
            .cfg_num_outputs (cfg_n),
            .cfg_vec_len     (cfg_v),
            .cfg_w_base      (cfg_wb),
            .cfg_a_base      (cfg_ab),
            .cfg_wait_ack    (cfg_wt),
            .abort_p         (abort_v[g]),
            .hw_mem_wr_ack_p (ack_v[g]),
            .rd_en           (rd_o[g]),
            .weight_rd_addr  (wa_o[g]),
            .act_rd_addr     (aa_o[g]),
            .mac_en          (mac_o[g]),
            .start_p         (st_o[g]),
            .last_p          (la_o[g]),
            .ch_num          (ch_o[g]),
            .busy            (busy_o[g]),
            .done_p          (done_o[g])
        );
    end

    // Scoreboard: reads pop expected addresses, neuron beats pop expected flags at rd+LAT.
    always @(negedge clk) begin : scoreboard
        rd_exp_t  r;
        mac_exp_t m;
        if (!rst) begin
            if (rd_o[sel]) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected cyc=%0d got w=%h a=%h, required no read", cyc, wa_o[sel], aa_o[sel]);
                end else begin
                    r = rd_q.pop_front();
                    due_q.push_back(cyc + lat_of[sel]);
                    if (wa_o[sel] !== r.w || aa_o[sel] !== r.a) begin
                        errors++;
                        $display("FAIL rd_addr cyc=%0d got w=%h a=%h, required w=%h a=%h", cyc, wa_o[sel], aa_o[sel], r.w, r.a);
                    end
                end
            end
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                m = mac_q.pop_front();
                checks++;
                if (mac_o[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL mac_missing cyc=%0d got mac_en=%b, required 1", cyc, mac_o[sel]);
                end else if ({st_o[sel], la_o[sel], ch_o[sel]} !== {m.first, m.last, m.ch}) begin
                    errors++;
                    $display("FAIL mac_flags cyc=%0d got start=%b last=%b ch=%0d, required start=%b last=%b ch=%0d",
                             cyc, st_o[sel], la_o[sel], ch_o[sel], m.first, m.last, m.ch);
                end
            end else if (mac_o[sel] || st_o[sel] || la_o[sel]) begin
                checks++;
                errors++;
                $display("FAIL mac_unexpected cyc=%0d got mac=%b start=%b last=%b, required all 0", cyc, mac_o[sel], st_o[sel], la_o[sel]);
            end
            if (done_o[sel]) begin
                done_cnt++;
                checks++;
                if (busy_o[sel] !== 1'b0) begin
                    errors++;
                    $display("FAIL done_busy cyc=%0d got busy=%b with done_p, required 0", cyc, busy_o[sel]);
                end
            end
        end
    end

    // Expected read/beat stream for a layer, from w_base + n*vec_len + k.
    task automatic push_layer(input int n, input int v, input logic [AW-1:0] wb, input logic [AW-1:0] ab);
        rd_exp_t  r;
        mac_exp_t m;
        for (int o = 0; o < n; o++) begin
            for (int k = 0; k < v; k++) begin
                r.w     = wb + AW'(o * v + k);
                r.a     = ab + AW'(k);
                m.first = (k == 0);
                m.last  = (k == v - 1);
                m.ch    = 5'(o);
                rd_q.push_back(r);
                mac_q.push_back(m);
            end
        end
    endtask

    task automatic start_layer(input logic [1:0] d, input int n, input int v, input int wb, input int ab,
                               input bit wt, input bit push);
        if (push) push_layer(n, v, AW'(wb), AW'(ab));
        @(posedge clk); #1;
        cfg_n   = LW'(n);
        cfg_v   = LW'(v);
        cfg_wb  = AW'(wb);
        cfg_ab  = AW'(ab);
        cfg_wt  = wt;
        start_v = 3'b001 << d;
        @(posedge clk); #1;
        start_v = '0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o[sel]) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rd_o[i], mac_o[i], st_o[i], la_o[i], busy_o[i], done_o[i]} !== 6'b0 ||
                wa_o[i] !== '0 || aa_o[i] !== '0 || ch_o[i] !== '0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got rd=%b mac=%b st=%b la=%b busy=%b done=%b w=%h a=%h ch=%0d, required all 0",
                         i, rd_o[i], mac_o[i], st_o[i], la_o[i], busy_o[i], done_o[i], wa_o[i], aa_o[i], ch_o[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        bit seen;
        int pat [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        sel = 2'd0; done_cnt = 0;
        start_layer(2'd0, 2, 3, 'h100, 'h20, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (rd_o[0] !== pat[i][0] || busy_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL basic_rd_pattern step=%0d got rd=%b busy=%b, required rd=%0d busy=1", i, rd_o[0], busy_o[0], pat[i]);
            end
        end
        wait_done(20, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_done got no done_p, required one"); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || rd_q.size() != 0 || mac_q.size() != 0 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got done=%0d rd_left=%0d mac_left=%0d busy=%b, required 1 0 0 0", done_cnt, rd_q.size(), mac_q.size(), busy_o[0]);
        end
    endtask

    task automatic test_wait_ack;
        bit seen;
        sel = 2'd0; done_cnt = 0;
        start_layer(2'd0, 3, 4, 'h0a0, 'h3c0, 1'b1, 1'b1);
        ack_v = 3'b001;
        @(posedge clk); #1;
        ack_v = '0;
        for (int n = 0; n < 3; n++) begin
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk);
                if (la_o[0]) seen = 1'b1;
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL ack_last_timeout out=%0d got no last_p, required one", n); end
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++;
                if (rd_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_stall out=%0d step=%0d got rd=%b busy=%b, required rd=0 busy=1", n, i, rd_o[0], busy_o[0]);
                end
            end
            @(posedge clk); #1;
            ack_v = 3'b001;
            @(posedge clk); #1;
            ack_v = '0;
        end
        wait_done(10, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL ack_done got no done_p, required one"); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || rd_q.size() != 0 || mac_q.size() != 0) begin
            errors++;
            $display("FAIL ack_end got done=%0d rd_left=%0d mac_left=%0d, required 1 0 0", done_cnt, rd_q.size(), mac_q.size());
        end
    endtask

    task automatic test_vec_len_one;
        bit seen;
        sel = 2'd2; done_cnt = 0;
        start_layer(2'd2, 4, 1, 'h010, 'h005, 1'b0, 1'b1);
        wait_done(80, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL vec1_done got no done_p, required one"); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || rd_q.size() != 0 || mac_q.size() != 0) begin
            errors++;
            $display("FAIL vec1_end got done=%0d rd_left=%0d mac_left=%0d, required 1 0 0", done_cnt, rd_q.size(), mac_q.size());
        end
    endtask

    task automatic test_zero_len;
        int ns [2] = '{0, 3};
        int vs [2] = '{5, 0};
        sel = 2'd0;
        for (int c = 0; c < 2; c++) begin
            done_cnt = 0;
            start_layer(2'd0, ns[c], vs[c], 'h111, 'h022, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL zero_c1 case=%0d got busy=%b done=%b, required 1 0", c, busy_o[0], done_o[0]);
            end
            @(negedge clk);
            checks++;
            if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL zero_c2 case=%0d got busy=%b done=%b, required 0 1", c, busy_o[0], done_o[0]);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (done_cnt != 1) begin
                errors++;
                $display("FAIL zero_done_count case=%0d got %0d, required 1", c, done_cnt);
            end
        end
    endtask

    task automatic test_abort;
        bit seen;
        sel = 2'd1; done_cnt = 0;
        start_layer(2'd1, 3, 3, 'h200, 'h010, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        abort_v = 3'b010;
        @(posedge clk); #1;
        abort_v = '0;
        rd_q.delete(); mac_q.delete(); due_q.delete();
        @(negedge clk);
        checks++;
        if (busy_o[1] !== 1'b0 || rd_o[1] !== 1'b0 || mac_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_next got busy=%b rd=%b mac=%b, required 0 0 0", busy_o[1], rd_o[1], mac_o[1]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d done_p, required 0", done_cnt); end
        start_layer(2'd1, 1, 3, 'h3ffe, 'h3fff, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (ch_o[1] !== 5'd0 || rd_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart got ch=%0d rd=%b, required ch=0 rd=1", ch_o[1], rd_o[1]);
        end
        wait_done(30, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_restart_done got no done_p, required one"); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || rd_q.size() != 0 || mac_q.size() != 0) begin
            errors++;
            $display("FAIL abort_end got done=%0d rd_left=%0d mac_left=%0d, required 1 0 0", done_cnt, rd_q.size(), mac_q.size());
        end
    endtask

    task automatic test_back_to_back_start;
        bit seen;
        sel = 2'd0; done_cnt = 0;
        start_layer(2'd0, 2, 3, 'h200, 'h040, 1'b0, 1'b1);
        start_layer(2'd0, 1, 1, 'h300, 'h050, 1'b0, 1'b0);
        wait_done(40, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL restart_done got no done_p, required one"); end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != 1 || rd_q.size() != 0 || mac_q.size() != 0) begin
            errors++;
            $display("FAIL restart_end got done=%0d rd_left=%0d mac_left=%0d, required 1 0 0", done_cnt, rd_q.size(), mac_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_ack();
        test_vec_len_one();
        test_zero_len();
        test_abort();
        test_back_to_back_start();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
